issue_queue_fifo: RTL and testbench

In-order instruction issue queue built around a circular synchronous FIFO. It sits between the dispatcher and one execution unit (integer ALU, FP ALU or AGU). It buffers decoded 32-bit instructions and tracks per-entry source-operand readiness via writeback broadcasts. It presents the head entry and its issue status to the execution unit.

---
 rtl/issue_queue_fifo_if.sv | 38 +++
 rtl/issue_queue_fifo.sv | 144 ++++++++++++++
 tb/tb_issue_queue_fifo.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_fifo_if.sv
// rtl/issue_queue_fifo_if.sv - dispatcher/execution-unit handshake bundle for the issue queue
//
// Purpose: groups the issue queue's enqueue, dequeue, wakeup and head-view
// signals so the queue and its surroundings connect through one port.
// Signals:
//   enq, deq       push / pop requests
//   data_in        instruction to push (rs1=[19:15], rs2=[24:20])
//   ready_i        execution unit can accept an instruction this cycle
//   rs1_i, rs2_i   enqueue-time operand status, [32]=busy
//   rd_i           writeback broadcast, [32]=valid, [4:0]=register
//   data_out       head entry view
//   full, empty    occupancy flags
// Modports: master (driver side), slave (the queue).
interface issue_queue_fifo_if #(
  parameter int XLEN        = 32,
  parameter int FIELD_WIDTH = 55
);
  logic                   enq;
  logic                   deq;
  logic [XLEN-1:0]        data_in;
  logic                   ready_i;
  logic [32:0]            rs1_i;
  logic [32:0]            rs2_i;
  logic [32:0]            rd_i;
  logic [FIELD_WIDTH-1:0] data_out;
  logic                   full;
  logic                   empty;

  modport master (
    output enq, deq, data_in, ready_i, rs1_i, rs2_i, rd_i,
    input  data_out, full, empty
  );

  modport slave (
    input  enq, deq, data_in, ready_i, rs1_i, rs2_i, rd_i,
    output data_out, full, empty
  );
endinterface

// File: rtl/issue_queue_fifo.sv
// rtl/issue_queue_fifo.sv - in-order issue queue on a circular FIFO with operand wakeup
//
// Purpose: buffers decoded instructions between dispatch and one execution
// unit, tracks per-entry rs1/rs2 readiness from writeback broadcasts and
// presents the head entry with its issue status.
// Ports:
//   clk     rising-edge clock
//   resetn  synchronous, active-low reset
//   bus     issue_queue_fifo_if.slave (enq/deq/data_in/ready_i/rs1_i/rs2_i/
//           rd_i in, data_out/full/empty out)
// data_out layout: [XLEN-1:0] instr, [XLEN] rs1_rdy, [XLEN+1] rs2_rdy,
//   [XLEN+2] valid, [XLEN+3] issuable, [XLEN+4 +: CW] occupancy, rest 0.
// Build option: IQ_BYPASS_EN - a broadcast coincident with an enqueue also
//   sets the ready bits of the entry being written.
module issue_queue_fifo #(
  parameter int XLEN        = 32,
  parameter int FIELD_WIDTH = 55,
  parameter int DEPTH       = 8
) (
  input  logic             clk,
  input  logic             resetn,
  issue_queue_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [XLEN-1:0]  instr_q [DEPTH];
  logic [DEPTH-1:0] rs1_rdy_q, rs1_rdy_d;
  logic [DEPTH-1:0] rs2_rdy_q, rs2_rdy_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic             full_w;
  logic             empty_w;
  logic             do_enq;
  logic             do_deq;
  logic             rd_valid;
  logic [4:0]       rd_reg;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic             new_rs1_rdy;
  logic             new_rs2_rdy;
  logic             unused_bits;

  assign full_w   = (count_q == CW'(DEPTH));
  assign empty_w  = (count_q == '0);

  // When full, a simultaneous pop frees the slot the push lands in.
  assign do_enq   = bus.enq && (!full_w || bus.deq);
  assign do_deq   = bus.deq && !empty_w;

  assign rd_valid = bus.rd_i[32];
  assign rd_reg   = bus.rd_i[4:0];
  assign in_rs1   = bus.data_in[19:15];
  assign in_rs2   = bus.data_in[24:20];

`ifdef IQ_BYPASS_EN
  assign new_rs1_rdy = !bus.rs1_i[32] || (in_rs1 == 5'd0) ||
                       (rd_valid && (rd_reg == in_rs1));
  assign new_rs2_rdy = !bus.rs2_i[32] || (in_rs2 == 5'd0) ||
                       (rd_valid && (rd_reg == in_rs2));
`else
  assign new_rs1_rdy = !bus.rs1_i[32] || (in_rs1 == 5'd0);
  assign new_rs2_rdy = !bus.rs2_i[32] || (in_rs2 == 5'd0);
`endif

  assign unused_bits = ^{bus.rs1_i[31:0], bus.rs2_i[31:0], bus.rd_i[31:5]};

  always_comb begin
    rs1_rdy_d = rs1_rdy_q;
    rs2_rdy_d = rs2_rdy_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    // Wakeup only touches resident entries: slot i is resident when its
    // distance from head is below the occupancy count. x0 never wakes.
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_valid && ({1'b0, PTR_W'(i) - head_q} < count_q)) begin
        if ((instr_q[i][19:15] == rd_reg) && (rd_reg != 5'd0)) rs1_rdy_d[i] = 1'b1;
        if ((instr_q[i][24:20] == rd_reg) && (rd_reg != 5'd0)) rs2_rdy_d[i] = 1'b1;
      end
    end

    // The enqueue write wins over wakeup for the tail slot; in the full
    // enq+deq case that slot is the one being popped.
    if (do_enq) begin
      rs1_rdy_d[tail_q] = new_rs1_rdy;
      rs2_rdy_d[tail_q] = new_rs2_rdy;
      tail_d            = tail_q + PTR_W'(1);
    end

    if (do_deq) begin
      head_d = head_q + PTR_W'(1);
    end

    if (do_enq && !do_deq) begin
      count_d = count_q + CW'(1);
    end else if (!do_enq && do_deq) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      rs1_rdy_q <= rs1_rdy_d;
      rs2_rdy_q <= rs2_rdy_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Instruction storage needs no reset: data_out masks it while empty.
  always_ff @(posedge clk) begin
    if (resetn && do_enq) begin
      instr_q[tail_q] <= bus.data_in;
    end
  end

  always_comb begin
    bus.data_out = '0;
    bus.data_out[XLEN+4 +: CW] = count_q;
    if (!empty_w) begin
      bus.data_out[XLEN-1:0] = instr_q[head_q];
      bus.data_out[XLEN]     = rs1_rdy_q[head_q];
      bus.data_out[XLEN+1]   = rs2_rdy_q[head_q];
      bus.data_out[XLEN+2]   = 1'b1;
      bus.data_out[XLEN+3]   = rs1_rdy_q[head_q] & rs2_rdy_q[head_q] & bus.ready_i;
    end
  end

  assign bus.full  = full_w;
  assign bus.empty = empty_w;

endmodule

// File: tb/tb_issue_queue_fifo.sv
// tb/tb_issue_queue_fifo.sv - randomized and directed check of issue_queue_fifo against a queue model
module tb_issue_queue_fifo;

  localparam int XLEN  = 32;
  localparam int FW    = 55;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

`ifdef IQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;

  issue_queue_fifo_if #(.XLEN(XLEN), .FIELD_WIDTH(FW)) bus ();

  issue_queue_fifo #(.XLEN(XLEN), .FIELD_WIDTH(FW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        r1;
    logic        r2;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] exp_dout(input logic rdy);
    logic [FW-1:0] d;
    d = '0;
    d[XLEN+4 +: CW] = CW'(q.size());
    if (q.size() > 0) begin
      d[XLEN-1:0] = q[0].instr;
      d[XLEN]     = q[0].r1;
      d[XLEN+1]   = q[0].r2;
      d[XLEN+2]   = 1'b1;
      d[XLEN+3]   = q[0].r1 & q[0].r2 & rdy;
    end
    return d;
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2);
    logic [31:0] x;
    x = $urandom();
    x[19:15] = rs1;
    x[24:20] = rs2;
    return x;
  endfunction

  // One clock: drive inputs, compare outputs against the model, then let the
  // edge happen and advance the model by the same request.
  task automatic step(input logic e, input logic d, input logic [31:0] ins,
                      input logic b1, input logic b2, input logic rv,
                      input logic [4:0] rr, input logic rdy);
    ent_t n;
    ent_t t;
    logic deq_ok;
    logic enq_ok;
    @(negedge clk);
    resetn      = 1'b1;
    bus.enq     = e;
    bus.deq     = d;
    bus.data_in = ins;
    bus.rs1_i   = {b1, 32'($urandom())};
    bus.rs2_i   = {b2, 32'($urandom())};
    bus.rd_i    = {rv, 27'($urandom()), rr};
    bus.ready_i = rdy;
    #1;
    check("data_out", 64'(bus.data_out), 64'(exp_dout(rdy)));
    check("full", 64'(bus.full), 64'(q.size() == DEPTH));
    check("empty", 64'(bus.empty), 64'(q.size() == 0));
    @(posedge clk);
    deq_ok = d && (q.size() > 0);
    enq_ok = e && ((q.size() < DEPTH) || d);
    if (rv && rr != 5'd0) begin
      foreach (q[k]) begin
        t = q[k];
        if (t.instr[19:15] == rr) t.r1 = 1'b1;
        if (t.instr[24:20] == rr) t.r2 = 1'b1;
        q[k] = t;
      end
    end
    if (deq_ok) void'(q.pop_front());
    if (enq_ok) begin
      n.instr = ins;
      n.r1 = !b1 || (ins[19:15] == 5'd0) || (BYP && rv && (ins[19:15] == rr));
      n.r2 = !b2 || (ins[24:20] == 5'd0) || (BYP && rv && (ins[24:20] == rr));
      q.push_back(n);
    end
  endtask

  task automatic push_free(input logic [31:0] ins);
    step(1'b1, 1'b0, ins, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
  endtask

  task automatic pop_one();
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
  endtask

  task automatic rand_step(input int pe, input int pd);
    step($urandom_range(0, 99) < pe, $urandom_range(0, 99) < pd,
         mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
         1'($urandom()), 1'($urandom()), 1'($urandom()),
         5'($urandom_range(0, 3)), 1'($urandom()));
  endtask

  logic [31:0] marker;

  initial begin
    bus.enq = 1'b0; bus.deq = 1'b0; bus.data_in = '0; bus.ready_i = 1'b0;
    bus.rs1_i = '0; bus.rs2_i = '0; bus.rd_i = '0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_data_out", 64'(bus.data_out), 64'd0);
    check("reset_empty", 64'(bus.empty), 64'd1);
    check("reset_full", 64'(bus.full), 64'd0);

    // Fill, overflow, drain in order.
    for (int i = 0; i < DEPTH; i++) push_free(mk(5'(i), 5'(i + 1)));
    #1;
    check("full_after_8", 64'(bus.full), 64'd1);
    check("count_8", 64'(bus.data_out[XLEN+4 +: CW]), 64'd8);
    push_free(32'hFFFF_FFFF);
    #1;
    check("drop_9th_count", 64'(bus.data_out[XLEN+4 +: CW]), 64'd8);
    for (int i = 0; i < DEPTH; i++) pop_one();
    #1;
    check("drained_empty", 64'(bus.empty), 64'd1);

    // add x3,x1,x2 waits on x1, woken by broadcast of x1.
    step(1'b1, 1'b0, 32'h0020_81B3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    #1;
    check("add_rs1_rdy", 64'(bus.data_out[XLEN]), 64'd0);
    check("add_issuable", 64'(bus.data_out[XLEN+3]), 64'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1);
    #1;
    check("wake_rs1_rdy", 64'(bus.data_out[XLEN]), 64'd1);
    check("wake_issuable", 64'(bus.data_out[XLEN+3]), 64'd1);
    pop_one();

    // Full queue with enq+deq: count holds, new entry at wrapped tail.
    for (int i = 0; i < DEPTH; i++) push_free(mk(5'd0, 5'd0));
    marker = 32'hCAFE_0013;
    step(1'b1, 1'b1, marker, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    #1;
    check("full_swap_count", 64'(bus.data_out[XLEN+4 +: CW]), 64'd8);
    for (int i = 0; i < DEPTH - 1; i++) pop_one();
    #1;
    check("wrapped_tail", 64'(bus.data_out[XLEN-1:0]), 64'(marker));
    pop_one();

    // rs1 = x0 is always ready even if marked busy.
    step(1'b1, 1'b0, mk(5'd0, 5'd3), 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    #1;
    check("x0_rs1_rdy", 64'(bus.data_out[XLEN]), 64'd1);
    pop_one();

    // Broadcast coincident with enqueue.
    step(1'b1, 1'b0, mk(5'd5, 5'd0), 1'b1, 1'b1, 1'b1, 5'd5, 1'b1);
    #1;
    check("bypass_rs1_rdy", 64'(bus.data_out[XLEN]), 64'(BYP));
    pop_one();

    // Reset with entries queued overrides concurrent requests.
    for (int i = 0; i < 5; i++) push_free(mk(5'd2, 5'd3));
    @(negedge clk);
    resetn = 1'b0; bus.enq = 1'b1; bus.deq = 1'b0; bus.rd_i = {1'b1, 27'd0, 5'd2};
    @(posedge clk);
    q.delete();
    #1;
    check("reset5_empty", 64'(bus.empty), 64'd1);
    check("reset5_count", 64'(bus.data_out[XLEN+4 +: CW]), 64'd0);

    // Randomized traffic with shifting fill/drain bias.
    for (int i = 0; i < 800; i++) begin
      case ((i / 100) % 4)
        0: rand_step(80, 20);
        1: rand_step(50, 50);
        2: rand_step(20, 80);
        default: rand_step(90, 60);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
